sonar_trigger_gen: RTL

Ultrasonic rangefinder trigger sequencer for the telemetre datapath. It is the emitting side of the echo-measurement chain. It drives the sensor's Trig pin with a fixed-width pulse and emits a one-cycle MeasStart strobe that clears the echo-width counter. It then enforces a minimum holdoff before the next shot, either on demand or free-running. It is built around a loadable down-counter and a three-state FSM.

---
 rtl/sonar_trigger_gen.sv | 102 ++++++++++
 1 files changed

// File: rtl/sonar_trigger_gen.sv
// Ultrasonic rangefinder trigger sequencer: fixed-width Trig pulse, MeasStart strobe,
// then an enforced holdoff so shots are spaced PERIOD_CYCLES apart (single or free-running).
module sonar_trigger_gen #(
    parameter int TRIG_CYCLES   = 500,
    parameter int PERIOD_CYCLES = 3000000,
    parameter int CNT_WIDTH     = 22
) (
    input  logic Clk,
    input  logic nReset,
    input  logic Start,
    input  logic Continuous,
    output logic Trig,
    output logic Busy,
    output logic MeasStart,
    output logic Done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TRIG    = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LD_TRIG = CNT_WIDTH'(TRIG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LD_HOLD = CNT_WIDTH'(PERIOD_CYCLES - TRIG_CYCLES - 1);

    state_t               r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic                 r_trig, r_busy, r_meas, r_done;
    logic                 w_trig_nxt, w_busy_nxt, w_meas_nxt, w_done_nxt;
    logic                 w_req;

    assign w_req = Start | Continuous;

    // State, counter and output flops; outputs are registered copies of next-state decode
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_trig  <= 1'b0;
            r_busy  <= 1'b0;
            r_meas  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_trig  <= w_trig_nxt;
            r_busy  <= w_busy_nxt;
            r_meas  <= w_meas_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = S_TRIG;
                    w_cnt_nxt   = LD_TRIG;
                end
            end
            S_TRIG: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
                end else begin
                    w_state_nxt = S_HOLDOFF;
                    w_cnt_nxt   = LD_HOLD;
                end
            end
            S_HOLDOFF: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
                end else if (w_req) begin
                    // chaining straight into TRIG keeps the period exact with no idle cycle
                    w_state_nxt = S_TRIG;
                    w_cnt_nxt   = LD_TRIG;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_trig_nxt = (w_state_nxt == S_TRIG);
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_meas_nxt = (w_state_nxt == S_HOLDOFF) && (r_state != S_HOLDOFF);
        w_done_nxt = (w_state_nxt == S_HOLDOFF) && (w_cnt_nxt == '0);
    end

    assign Trig      = r_trig;
    assign Busy      = r_busy;
    assign MeasStart = r_meas;
    assign Done      = r_done;

endmodule
